ext_intr_ctrl: RTL and testbench

EXT_INTR_CTRL -- requirements
Module: ext_intr_ctrl

---
 rtl/ext_intr_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ext_intr_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_intr_ctrl.sv
// ext_intr_ctrl
// External interrupt controller that sits between raw peripheral lines and
// the core's CSR unit. Each source is synchronized and edge-detected. A
// detected edge sets a sticky pending bit, and an enable mask gates which
// pending bits may raise a request. A three-state handshake (IDLE/REQ/SERVICE)
// hands one claimed source at a time to the core.
//
// Ports
//   clk             : single clock, all state changes on its rising edge
//   rst             : asynchronous active-low reset
//   src_irq         : raw asynchronous interrupt lines, one per source
//   en_we           : write strobe for the enable mask
//   en_wdata        : new enable mask value
//   intr_ack        : one-cycle claim pulse from the core on trap entry
//   intr_eoi        : one-cycle end-of-service pulse from the core on mret
//   External_Intrpt : level request to the CSR unit, high only in REQ
//   claim_id        : index of the claimed source, held through SERVICE
//   claim_valid     : high while claim_id is valid (state SERVICE)
//   pending         : current pending vector
module ext_intr_ctrl #(
    parameter int NSRC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_irq,
    input  logic                    en_we,
    input  logic [NSRC-1:0]         en_wdata,
    input  logic                    intr_ack,
    input  logic                    intr_eoi,
    output logic                    External_Intrpt,
    output logic [$clog2(NSRC)-1:0] claim_id,
    output logic                    claim_valid,
    output logic [NSRC-1:0]         pending
);

    localparam int IDW = $clog2(NSRC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] sync3;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] clr_mask;
    logic [IDW-1:0]  win_id;
    logic            take;

    // sync1/sync2 form the metastability synchronizer; sync3 is the delayed
    // copy used to spot a 0->1 transition on the synchronized line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= src_irq;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise   = sync2 & ~sync3;
    assign active = pending & enable;

    // Lowest index wins, so scan from the top down and let lower bits
    // overwrite the choice.
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    // A claim is only honoured in REQ with something actually claimable.
    assign take = (state == REQ) && intr_ack && (|active);

    always_comb begin
        clr_mask = '0;
        if (take) begin
            clr_mask[win_id] = 1'b1;
        end
    end

    // Pending bits are sticky: a new edge is ORed in after the claim clear so
    // an edge landing on the claimed source keeps it pending. Masking never
    // touches pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    // Enable mask register, written directly by the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable <= '0;
        end else if (en_we) begin
            enable <= en_wdata;
        end
    end

    // claim_id only changes on a successful claim, so it stays stable for
    // the whole SERVICE period regardless of new edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            claim_id <= '0;
        end else if (take) begin
            claim_id <= win_id;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. REQ falls back to IDLE when every pending source has
    // been masked off; a stray ack or eoi in the wrong state is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|active) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!(|active)) begin
                    state_next = IDLE;
                end else if (intr_ack) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (intr_eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register, so nothing on the
    // inputs reaches them combinationally.
    always_comb begin
        External_Intrpt = (state == REQ);
        claim_valid     = (state == SERVICE);
    end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// tb_ext_intr_ctrl
// Self-checking bench for ext_intr_ctrl with NSRC=4. A table of hand-derived
// vectors walks through the basic flow, priority, masking, stray handshakes,
// and the set-beats-clear coincidence. Hand-written sequences then cover the
// asynchronous reset during SERVICE and a source already high at release.
// Expected results are queued when stimulus is driven and popped when the
// outputs are sampled, 1 ns after the rising edge.
module tb_ext_intr_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] src_irq;
    logic       en_we;
    logic [3:0] en_wdata;
    logic       intr_ack;
    logic       intr_eoi;
    logic       External_Intrpt;
    logic [1:0] claim_id;
    logic       claim_valid;
    logic [3:0] pending;

    int total;
    int bad;

    typedef struct {
        logic [3:0] src;
        logic       we;
        logic [3:0] wdata;
        logic       ack;
        logic       eoi;
        logic       x_intr;
        logic       x_valid;
        logic [1:0] x_id;
        logic [3:0] x_pend;
    } vec_t;

    typedef struct {
        string      name;
        logic       intr;
        logic       valid;
        logic [1:0] id;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[48];

    ext_intr_ctrl #(.NSRC(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_irq         (src_irq),
        .en_we           (en_we),
        .en_wdata        (en_wdata),
        .intr_ack        (intr_ack),
        .intr_eoi        (intr_eoi),
        .External_Intrpt (External_Intrpt),
        .claim_id        (claim_id),
        .claim_valid     (claim_valid),
        .pending         (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] src, input logic we, input logic [3:0] wdata,
                                input logic ack, input logic eoi, input logic x_intr,
                                input logic x_valid, input logic [1:0] x_id, input logic [3:0] x_pend);
        vec_t v;
        v.src = src; v.we = we; v.wdata = wdata; v.ack = ack; v.eoi = eoi;
        v.x_intr = x_intr; v.x_valid = x_valid; v.x_id = x_id; v.x_pend = x_pend;
        return v;
    endfunction

    task automatic pushExpect(input string name, input logic intr, input logic valid,
                              input logic [1:0] id, input logic [3:0] pend);
        exp_t e;
        e.name = name; e.intr = intr; e.valid = valid; e.id = id; e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: output sampled with no expectation queued");
        end else begin
            e = sb.pop_front();
            if ({External_Intrpt, claim_valid, claim_id, pending} !== {e.intr, e.valid, e.id, e.pend}) begin
                bad++;
                $display("[TB] FAIL %s: got intr=%b valid=%b id=%0d pend=%b, want intr=%b valid=%b id=%0d pend=%b",
                         e.name, External_Intrpt, claim_valid, claim_id, pending,
                         e.intr, e.valid, e.id, e.pend);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // sample just after the edge.
    task automatic applyStimulus(input string name, input vec_t v);
        src_irq  = v.src;
        en_we    = v.we;
        en_wdata = v.wdata;
        intr_ack = v.ack;
        intr_eoi = v.eoi;
        pushExpect(name, v.x_intr, v.x_valid, v.x_id, v.x_pend);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // basic flow with enable=0001
        vecs[0]  = mk(4'b0000, 1, 4'b0001, 0, 0, 0, 0, 2'd0, 4'b0000);
        vecs[1]  = mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000);
        vecs[2]  = mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000);
        vecs[3]  = mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0001);
        vecs[4]  = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0001);
        vecs[5]  = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0001);
        vecs[6]  = mk(4'b0000, 0, 4'b0000, 1, 0, 0, 1, 2'd0, 4'b0000);
        vecs[7]  = mk(4'b0000, 0, 4'b0000, 0, 0, 0, 1, 2'd0, 4'b0000);
        vecs[8]  = mk(4'b0000, 0, 4'b0000, 0, 1, 0, 0, 2'd0, 4'b0000);
        // priority: sources 3 and 1 together, enable=1111
        vecs[9]  = mk(4'b0000, 1, 4'b1111, 0, 0, 0, 0, 2'd0, 4'b0000);
        vecs[10] = mk(4'b1010, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000);
        vecs[11] = mk(4'b1010, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000);
        vecs[12] = mk(4'b1010, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b1010);
        vecs[13] = mk(4'b1010, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b1010);
        vecs[14] = mk(4'b1010, 0, 4'b0000, 1, 0, 0, 1, 2'd1, 4'b1000);
        vecs[15] = mk(4'b1010, 0, 4'b0000, 0, 1, 0, 0, 2'd1, 4'b1000);
        vecs[16] = mk(4'b1010, 0, 4'b0000, 0, 0, 1, 0, 2'd1, 4'b1000);
        vecs[17] = mk(4'b1010, 0, 4'b0000, 1, 0, 0, 1, 2'd3, 4'b0000);
        vecs[18] = mk(4'b0000, 0, 4'b0000, 0, 1, 0, 0, 2'd3, 4'b0000);
        // masking: source 2 pends while disabled, then enable/disable
        vecs[19] = mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0000);
        vecs[20] = mk(4'b0100, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0000);
        vecs[21] = mk(4'b0100, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0000);
        vecs[22] = mk(4'b0100, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0100);
        vecs[23] = mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0100);
        vecs[24] = mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0100);
        vecs[25] = mk(4'b0000, 1, 4'b0100, 0, 0, 0, 0, 2'd3, 4'b0100);
        vecs[26] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd3, 4'b0100);
        vecs[27] = mk(4'b0000, 1, 4'b0000, 0, 0, 1, 0, 2'd3, 4'b0100);
        vecs[28] = mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 2'd3, 4'b0100);
        // stray handshakes: ack in IDLE, eoi in REQ
        vecs[29] = mk(4'b0000, 0, 4'b0000, 1, 0, 0, 0, 2'd3, 4'b0100);
        vecs[30] = mk(4'b0000, 1, 4'b0100, 0, 0, 0, 0, 2'd3, 4'b0100);
        vecs[31] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd3, 4'b0100);
        vecs[32] = mk(4'b0000, 0, 4'b0000, 0, 1, 1, 0, 2'd3, 4'b0100);
        vecs[33] = mk(4'b0000, 0, 4'b0000, 1, 0, 0, 1, 2'd2, 4'b0000);
        vecs[34] = mk(4'b0000, 0, 4'b0000, 0, 1, 0, 0, 2'd2, 4'b0000);
        // coincidence: second edge on source 0 lands with the ack of source 0
        vecs[35] = mk(4'b0000, 1, 4'b0001, 0, 0, 0, 0, 2'd2, 4'b0000);
        vecs[36] = mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd2, 4'b0000);
        vecs[37] = mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd2, 4'b0000);
        vecs[38] = mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd2, 4'b0001);
        vecs[39] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd2, 4'b0001);
        vecs[40] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd2, 4'b0001);
        vecs[41] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd2, 4'b0001);
        vecs[42] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd2, 4'b0001);
        vecs[43] = mk(4'b0001, 0, 4'b0000, 0, 0, 1, 0, 2'd2, 4'b0001);
        vecs[44] = mk(4'b0001, 0, 4'b0000, 0, 0, 1, 0, 2'd2, 4'b0001);
        vecs[45] = mk(4'b0001, 0, 4'b0000, 1, 0, 0, 1, 2'd0, 4'b0001);
        vecs[46] = mk(4'b0000, 0, 4'b0000, 0, 1, 0, 0, 2'd0, 4'b0001);
        vecs[47] = mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0001);

        rst      = 1'b0;
        src_irq  = '0;
        en_we    = 1'b0;
        en_wdata = '0;
        intr_ack = 1'b0;
        intr_eoi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pushExpect("reset_state", 0, 0, 2'd0, 4'b0000);
        checkOutput();

        rst = 1'b1;
        for (int i = 0; i < 48; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Claim source 0, then pull reset between edges during SERVICE.
        applyStimulus("svc_before_reset", mk(4'b0000, 0, 4'b0000, 1, 0, 0, 1, 2'd0, 4'b0000));
        #3;
        rst = 1'b0;
        #1;
        pushExpect("async_reset_no_edge", 0, 0, 2'd0, 4'b0000);
        checkOutput();
        applyStimulus("held_in_reset", mk(4'b0001, 1, 4'b0001, 0, 0, 0, 0, 2'd0, 4'b0000));

        // Source 0 is already high when reset lifts; it must count as a rise.
        rst = 1'b1;
        applyStimulus("release_r1", mk(4'b0001, 1, 4'b0001, 0, 0, 0, 0, 2'd0, 4'b0000));
        applyStimulus("release_r2", mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000));
        applyStimulus("release_r3", mk(4'b0001, 0, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0001));
        applyStimulus("release_r4", mk(4'b0001, 0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
